// File: rtl/rf_pkg.sv
// Shared sizes and types for the operand-read stage: lane/register geometry,
// the buffered operand bundle and the output buffer occupancy states.
package rf_pkg;

  localparam int LANES  = 16;
  localparam int NREGS  = 16;
  localparam int ADDR_W = $clog2(NREGS);
  localparam int DATA_W = 64;
  localparam int TAG_W  = 8;

  typedef logic [DATA_W-1:0] lane_data_t;

  typedef struct packed {
    logic [LANES*DATA_W-1:0] op0;
    logic [LANES*DATA_W-1:0] op1;
    logic [LANES-1:0]        mask;
    logic [TAG_W-1:0]        tag;
  } rr_bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } rr_state_e;

endpackage

// File: rtl/rr_lane_bypass.sv
// One lane of one operand: zero for inactive lanes or unused operands,
// otherwise the same-cycle bank write wins over the (stale) bank read data.
module rr_lane_bypass
  import rf_pkg::*;
(
  input  logic       mask_bit,
  input  logic       use_op,
  input  logic       wb_en_bit,
  input  logic       wb_hit,
  input  lane_data_t wb_lane,
  input  lane_data_t rd_lane,
  output lane_data_t lane_out
);

  // NOTE: every branch assigns lane_out, so this stays pure combinational logic (no latch).
  always_comb begin
    if (!mask_bit || !use_op) begin
      lane_out = '0;
    end else if (wb_en_bit && wb_hit) begin
      lane_out = wb_lane;
    end else begin
      lane_out = rd_lane;
    end
  end

endmodule

// File: rtl/register_read_stage.sv
// Operand-read stage: reads both bank ports in the accept cycle, bypasses
// same-cycle bank writes, and queues operand bundles in a 2-entry FIFO.
module register_read_stage
  import rf_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_rs0,
  input  logic [ADDR_W-1:0]       in_rs1,
  input  logic                    in_use0,
  input  logic                    in_use1,
  input  logic [LANES-1:0]        in_mask,
  input  logic [TAG_W-1:0]        in_tag,
  output logic [LANES-1:0]        read_en_0,
  output logic [LANES-1:0]        read_en_1,
  output logic [ADDR_W-1:0]       raddr_0,
  output logic [ADDR_W-1:0]       raddr_1,
  input  logic [LANES*DATA_W-1:0] rdata_0,
  input  logic [LANES*DATA_W-1:0] rdata_1,
  input  logic [LANES-1:0]        wb_en,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [LANES*DATA_W-1:0] wb_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_op0,
  output logic [LANES*DATA_W-1:0] out_op1,
  output logic [LANES-1:0]        out_mask,
  output logic [TAG_W-1:0]        out_tag
);

  rr_state_e         state_q, state_d;
  rr_bundle_t        head_q, head_d;
  rr_bundle_t        tail_q, tail_d;
  rr_bundle_t        in_bundle;
  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] raddr0_q, raddr0_d;
  logic [ADDR_W-1:0] raddr1_q, raddr1_d;
  logic              acc, pop, rd0, rd1;
  logic [LANES*DATA_W-1:0] cap_op0, cap_op1;

  assign in_ready  = in_ready_q;
  assign acc       = in_valid & in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign pop       = out_valid & out_ready;

  assign rd0       = acc & in_use0;
  assign rd1       = acc & in_use1;
  assign read_en_0 = rd0 ? in_mask : '0;
  assign read_en_1 = rd1 ? in_mask : '0;
  assign raddr_0   = raddr0_d;
  assign raddr_1   = raddr1_d;

  always_comb begin
    raddr0_d = rd0 ? in_rs0 : raddr0_q;
    raddr1_d = rd1 ? in_rs1 : raddr1_q;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    rr_lane_bypass u_byp0 (
      .mask_bit (in_mask[l]),
      .use_op   (in_use0),
      .wb_en_bit(wb_en[l]),
      .wb_hit   (wb_addr == in_rs0),
      .wb_lane  (wb_data[l*DATA_W +: DATA_W]),
      .rd_lane  (rdata_0[l*DATA_W +: DATA_W]),
      .lane_out (cap_op0[l*DATA_W +: DATA_W])
    );
    rr_lane_bypass u_byp1 (
      .mask_bit (in_mask[l]),
      .use_op   (in_use1),
      .wb_en_bit(wb_en[l]),
      .wb_hit   (wb_addr == in_rs1),
      .wb_lane  (wb_data[l*DATA_W +: DATA_W]),
      .rd_lane  (rdata_1[l*DATA_W +: DATA_W]),
      .lane_out (cap_op1[l*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    in_bundle.op0  = cap_op0;
    in_bundle.op1  = cap_op1;
    in_bundle.mask = in_mask;
    in_bundle.tag  = in_tag;
  end

  // Head is the presented bundle; tail only fills while the head is stalled.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = ONE;
          head_d  = in_bundle;
        end
      end
      ONE: begin
        case ({acc, pop})
          2'b10: begin
            state_d = TWO;
            tail_d  = in_bundle;
          end
          2'b01:   state_d = EMPTY;
          2'b11:   head_d  = in_bundle;
          default: state_d = ONE;
        endcase
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != TWO);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values; the
  // bundle registers are reset too because out_* must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
      raddr0_q   <= '0;
      raddr1_q   <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
      raddr0_q   <= raddr0_d;
      raddr1_q   <= raddr1_d;
    end
  end

  assign out_op0  = head_q.op0;
  assign out_op1  = head_q.op1;
  assign out_mask = head_q.mask;
  assign out_tag  = head_q.tag;

endmodule

// File: tb/tb_register_read_stage.sv
// Bench for register_read_stage with a behavioural register bank; expected
// bundles are queued at issue and popped by a monitor as the DUT emits them.
module tb_register_read_stage;
  import rf_pkg::*;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid, in_ready;
  logic [ADDR_W-1:0]       in_rs0, in_rs1;
  logic                    in_use0, in_use1;
  logic [LANES-1:0]        in_mask;
  logic [TAG_W-1:0]        in_tag;
  logic [LANES-1:0]        read_en_0, read_en_1;
  logic [ADDR_W-1:0]       raddr_0, raddr_1;
  logic [LANES*DATA_W-1:0] rdata_0, rdata_1;
  logic [LANES-1:0]        wb_en;
  logic [ADDR_W-1:0]       wb_addr;
  logic [LANES*DATA_W-1:0] wb_data;
  logic                    out_valid, out_ready;
  logic [LANES*DATA_W-1:0] out_op0, out_op1;
  logic [LANES-1:0]        out_mask;
  logic [TAG_W-1:0]        out_tag;

  int total = 0;
  int bad   = 0;
  int npop  = 0;
  rr_bundle_t sb[$];
  rr_bundle_t last_out;
  lane_data_t bank [NREGS][LANES];

  register_read_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs0(in_rs0), .in_rs1(in_rs1), .in_use0(in_use0), .in_use1(in_use1),
    .in_mask(in_mask), .in_tag(in_tag),
    .read_en_0(read_en_0), .read_en_1(read_en_1),
    .raddr_0(raddr_0), .raddr_1(raddr_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op0(out_op0), .out_op1(out_op1), .out_mask(out_mask), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural bank: combinational read, write at the clock edge.
  always_comb begin
    rdata_0 = '0;
    rdata_1 = '0;
    for (int l = 0; l < LANES; l++) begin
      rdata_0[l*DATA_W +: DATA_W] = bank[raddr_0][l];
      rdata_1[l*DATA_W +: DATA_W] = bank[raddr_1][l];
    end
  end

  always @(posedge clk) begin
    for (int l = 0; l < LANES; l++)
      if (wb_en[l]) bank[wb_addr][l] <= wb_data[l*DATA_W +: DATA_W];
  end

  function automatic lane_data_t lane_of(input logic [LANES*DATA_W-1:0] v, input int l);
    return v[l*DATA_W +: DATA_W];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [LANES*DATA_W-1:0] act,
                            input logic [LANES*DATA_W-1:0] exp);
    int first;
    total++;
    if (act !== exp) begin
      bad++;
      first = 0;
      for (int l = LANES - 1; l >= 0; l--)
        if (lane_of(act, l) !== lane_of(exp, l)) first = l;
      $display("FAIL %s: lane %0d got %h expected %h", name, first,
               lane_of(act, first), lane_of(exp, first));
    end
  endtask

  // Reference: operand value as seen by execute, bank state taken before the write edge.
  function automatic rr_bundle_t model(input logic [ADDR_W-1:0] rs0, input logic [ADDR_W-1:0] rs1,
                                       input logic u0, input logic u1,
                                       input logic [LANES-1:0] mask, input logic [TAG_W-1:0] tag);
    rr_bundle_t b;
    b = '0;
    b.mask = mask;
    b.tag  = tag;
    for (int l = 0; l < LANES; l++) begin
      if (mask[l] && u0)
        b.op0[l*DATA_W +: DATA_W] = (wb_en[l] && wb_addr == rs0) ?
                                    wb_data[l*DATA_W +: DATA_W] : bank[rs0][l];
      if (mask[l] && u1)
        b.op1[l*DATA_W +: DATA_W] = (wb_en[l] && wb_addr == rs1) ?
                                    wb_data[l*DATA_W +: DATA_W] : bank[rs1][l];
    end
    return b;
  endfunction

  // Monitor: every emitted bundle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    rr_bundle_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_bundle: got tag %h expected none", out_tag);
      end else begin
        e = sb.pop_front();
        check("out_tag", 64'(out_tag), 64'(e.tag));
        check("out_mask", 64'(out_mask), 64'(e.mask));
        check_wide("out_op0", out_op0, e.op0);
        check_wide("out_op1", out_op1, e.op1);
      end
      last_out = '{op0: out_op0, op1: out_op1, mask: out_mask, tag: out_tag};
      npop++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] rs0, input logic [ADDR_W-1:0] rs1,
                       input logic u0, input logic u1, input logic [LANES-1:0] mask,
                       input logic [TAG_W-1:0] tag, input logic exp_rdy);
    in_valid = 1'b1;
    in_rs0   = rs0;
    in_rs1   = rs1;
    in_use0  = u0;
    in_use1  = u1;
    in_mask  = mask;
    in_tag   = tag;
    @(negedge clk);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("read_en_0", 64'(read_en_0), 64'((exp_rdy && u0) ? mask : '0));
    check("read_en_1", 64'(read_en_1), 64'((exp_rdy && u1) ? mask : '0));
    if (exp_rdy && u0) check("raddr_0", 64'(raddr_0), 64'(rs0));
    if (exp_rdy && u1) check("raddr_1", 64'(raddr_1), 64'(rs1));
    if (exp_rdy) sb.push_back(model(rs0, rs1, u0, u1, mask, tag));
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [LANES*DATA_W-1:0] d;
    int pops_before;

    rst_n = 1'b0; in_valid = 1'b0; in_rs0 = '0; in_rs1 = '0;
    in_use0 = 1'b0; in_use1 = 1'b0; in_mask = '0; in_tag = '0;
    wb_en = '0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;

    // Reset and idle: nothing valid, ready, no bank reads.
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
    end
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_mask", 64'(out_mask), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_out_valid", 64'(out_valid), 64'd0);
      check("idle_in_ready", 64'(in_ready), 64'd1);
      check("idle_read_en_0", 64'(read_en_0), 64'd0);
      check("idle_read_en_1", 64'(read_en_1), 64'd0);
    end
    tick();

    // Preload r3 = lane*0x1111 and r7 = 0x0707...
    for (int l = 0; l < LANES; l++) d[l*DATA_W +: DATA_W] = 64'h1111 * l;
    wb_en = '1; wb_addr = 4'd3; wb_data = d;
    tick();
    wb_addr = 4'd7; wb_data = {LANES{64'h0707_0707_0707_0707}};
    tick();
    wb_en = '0;

    // rs0 == rs1 full-mask read, latency 1.
    issue(4'd3, 4'd3, 1'b1, 1'b1, 16'hFFFF, 8'hA1, 1'b1);
    @(negedge clk);
    check("lat1_out_valid", 64'(out_valid), 64'd1);
    tick();
    check_wide("same_reg_op0_eq_op1", last_out.op0, last_out.op1);
    check("same_reg_lane5", lane_of(last_out.op0, 5), 64'h5555);
    check("same_reg_lane15", lane_of(last_out.op1, 15), 64'hFFFF);

    // Same-cycle write to r7 must be bypassed into op0.
    wb_en = '1; wb_addr = 4'd7; wb_data = {LANES{64'hA5A5_A5A5_A5A5_A5A5}};
    issue(4'd7, 4'd3, 1'b1, 1'b1, 16'hFFFF, 8'hA2, 1'b1);
    wb_en = '0;
    @(negedge clk);
    tick();
    check("bypass_lane0", lane_of(last_out.op0, 0), 64'hA5A5_A5A5_A5A5_A5A5);
    check("bypass_lane9", lane_of(last_out.op0, 9), 64'hA5A5_A5A5_A5A5_A5A5);
    check("bypass_op1_lane5", lane_of(last_out.op1, 5), 64'h5555);

    // Partial mask, operand 1 unused.
    issue(4'd3, 4'd0, 1'b1, 1'b0, 16'h00FF, 8'hA3, 1'b1);
    @(negedge clk);
    tick();
    check("mask_lane2", lane_of(last_out.op0, 2), 64'h2222);
    check("mask_lane7", lane_of(last_out.op0, 7), 64'h7777);
    check("mask_lane8", lane_of(last_out.op0, 8), 64'h0);
    check_wide("mask_op1_zero", last_out.op1, '0);
    check("mask_out_mask", 64'(last_out.mask), 64'h00FF);

    // Backpressure: two accepted, third refused until the head drains.
    pops_before = npop;
    out_ready = 1'b0;
    issue(4'd3, 4'd7, 1'b1, 1'b1, 16'hFFFF, 8'd1, 1'b1);
    issue(4'd7, 4'd3, 1'b1, 1'b1, 16'hF0F0, 8'd2, 1'b1);
    issue(4'd3, 4'd3, 1'b1, 1'b1, 16'h0F0F, 8'd3, 1'b0);
    @(negedge clk);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_head_tag", 64'(out_tag), 64'd1);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b1;
    issue(4'd3, 4'd3, 1'b1, 1'b1, 16'h0F0F, 8'd3, 1'b0);
    issue(4'd3, 4'd3, 1'b1, 1'b1, 16'h0F0F, 8'd3, 1'b1);
    repeat (3) tick();
    check("drain_pop_count", 64'(npop - pops_before), 64'd3);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    check("drain_last_tag", 64'(last_out.tag), 64'd3);

    // Reset with a full buffer discards both bundles.
    out_ready = 1'b0;
    issue(4'd3, 4'd7, 1'b1, 1'b1, 16'hFFFF, 8'd4, 1'b1);
    issue(4'd7, 4'd7, 1'b1, 1'b1, 16'hFFFF, 8'd5, 1'b1);
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_tag", 64'(out_tag), 64'd0);
    tick();
    pops_before = npop;
    out_ready = 1'b1;
    repeat (5) tick();
    check("midrst_no_stale", 64'(npop - pops_before), 64'd0);
    issue(4'd7, 4'd3, 1'b1, 1'b1, 16'hFFFF, 8'd6, 1'b1);
    @(negedge clk);
    check("post_rst_out_valid", 64'(out_valid), 64'd1);
    tick();
    check("post_rst_tag", 64'(last_out.tag), 64'd6);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
